// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - op and FSM state encodings shared by the shifter and ALU control decode
package shifter_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational one-step shifter (value, op, s) -> value
// SEQ_SHIFTER_ROTATE_EN enables right-rotate for OP_ROR; otherwise OP_ROR shifts like SRL.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic [1:0]       op_i,
  input  logic [SHW-1:0]   amt_i,
  input  logic             sign_i,
  output logic [WIDTH-1:0] value_o
);

  logic [WIDTH-1:0] ones;
  logic [WIDTH-1:0] srl_val;
  logic [WIDTH-1:0] hi_mask;

  assign ones    = '1;
  assign srl_val = value_i >> amt_i;
  // Vacated MSB positions for this step; SRA fills them with the captured sign.
  assign hi_mask = ~(ones >> amt_i);

`ifdef SEQ_SHIFTER_ROTATE_EN
  logic [SHW:0] inv_amt;
  assign inv_amt = (SHW+1)'(WIDTH) - {1'b0, amt_i};
`endif

  always_comb begin
    value_o = srl_val;
    case (op_i)
      OP_SLL: value_o = value_i << amt_i;
      OP_SRA: value_o = sign_i ? (srl_val | hi_mask) : srl_val;
`ifdef SEQ_SHIFTER_ROTATE_EN
      OP_ROR: value_o = srl_val | (value_i << inv_amt);
`endif
      default: value_o = srl_val;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - multi-cycle SLL/SRL/SRA shifter, STEP bits per clock, Start/Busy/Done
// SEQ_SHIFTER_ROTATE_EN enables ROR for Op=11 (otherwise Op=11 behaves as SRL).
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [SHW-1:0]   ShAmt,
  input  logic [WIDTH-1:0] DataIn,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] DataOut
);

  localparam logic [SHW-1:0] STEP_W = SHW'(STEP);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [SHW-1:0]   rem_q, rem_d;
  logic [1:0]       op_q, op_d;
  logic             sign_q, sign_d;
  logic [SHW-1:0]   step_amt;
  logic [WIDTH-1:0] step_val;

  assign step_amt = (rem_q < STEP_W) ? rem_q : STEP_W;

  shift_step #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_step (
    .value_i (work_q),
    .op_i    (op_q),
    .amt_i   (step_amt),
    .sign_i  (sign_q),
    .value_o (step_val)
  );

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    dout_d  = dout_q;
    rem_d   = rem_q;
    op_d    = op_q;
    sign_d  = sign_q;
    case (state_q)
      ST_SHIFT: begin
        work_d = step_val;
        rem_d  = rem_q - step_amt;
        if (rem_q == step_amt) begin
          state_d = ST_DONE;
          dout_d  = step_val;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request, giving back-to-back issue from DONE.
        if (Start) begin
          work_d = DataIn;
          op_d   = Op;
          sign_d = DataIn[WIDTH-1];
          rem_d  = ShAmt;
          if (ShAmt == '0) begin
            state_d = ST_DONE;
            dout_d  = DataIn;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      dout_q  <= '0;
      rem_q   <= '0;
      op_q    <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      dout_q  <= dout_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
    end
  end

  assign Busy    = (state_q == ST_SHIFT);
  assign Done    = (state_q == ST_DONE);
  assign DataOut = dout_q;

endmodule

// File: tb/tb_seq_shifter.sv
// tb/tb_seq_shifter.sv - directed self-checking bench for seq_shifter (WIDTH=32, STEP=1)
module tb_seq_shifter;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [1:0]  Op;
  logic [4:0]  ShAmt;
  logic [31:0] DataIn;
  logic        Busy;
  logic        Done;
  logic [31:0] DataOut;

  int n_cmp;
  int n_fail;

  int          busy_cnt;
  int          cyc_cnt;
  logic        got_done;
  logic [31:0] res;
  logic [31:0] exp_ror1;
  logic [31:0] exp_ror4;

  seq_shifter #(.WIDTH(32), .STEP(1)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .Op      (Op),
    .ShAmt   (ShAmt),
    .DataIn  (DataIn),
    .Busy    (Busy),
    .Done    (Done),
    .DataOut (DataOut)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Issues one request (optionally on the current negedge for back-to-back) and waits for Done.
  task automatic run_op(input logic [1:0] op, input logic [4:0] amt, input logic [31:0] din,
                        input bit wait_first);
    if (wait_first) @(negedge Clk);
    Start  = 1'b1;
    Op     = op;
    ShAmt  = amt;
    DataIn = din;
    @(negedge Clk);
    Start    = 1'b0;
    DataIn   = 32'h5A5A_5A5A;
    busy_cnt = 0;
    cyc_cnt  = 0;
    while (!Done && cyc_cnt < 100) begin
      if (Busy) busy_cnt++;
      @(negedge Clk);
      cyc_cnt++;
    end
    got_done = Done;
    res      = DataOut;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    Reset  = 1'b1;
    Start  = 1'b0;
    Op     = 2'b00;
    ShAmt  = '0;
    DataIn = '0;
`ifdef SEQ_SHIFTER_ROTATE_EN
    exp_ror1 = 32'h8000_0000;
    exp_ror4 = 32'h8123_4567;
`else
    exp_ror1 = 32'h0000_0000;
    exp_ror4 = 32'h0123_4567;
`endif
    repeat (2) @(negedge Clk);
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_done", {31'd0, Done}, 32'd0);
    check("reset_dout", DataOut, 32'd0);
    Reset = 1'b0;

    run_op(2'b00, 5'd4, 32'h0000_0001, 1'b1);
    check("sll4_done", {31'd0, got_done}, 32'd1);
    check("sll4_busy_cycles", busy_cnt, 32'd4);
    check("sll4_result", res, 32'h0000_0010);
    @(negedge Clk);
    check("sll4_done_pulse", {31'd0, Done}, 32'd0);
    check("sll4_hold", DataOut, 32'h0000_0010);

    run_op(2'b10, 5'd31, 32'h8000_0000, 1'b1);
    check("sra31_cycles", cyc_cnt, 32'd31);
    check("sra31_result", res, 32'hFFFF_FFFF);
    run_op(2'b01, 5'd31, 32'h8000_0000, 1'b0);
    check("b2b_srl31_done", {31'd0, got_done}, 32'd1);
    check("b2b_srl31_cycles", cyc_cnt, 32'd31);
    check("b2b_srl31_result", res, 32'h0000_0001);

    run_op(2'b00, 5'd0, 32'hDEAD_BEEF, 1'b1);
    check("zero_cycles", cyc_cnt, 32'd0);
    check("zero_busy", busy_cnt, 32'd0);
    check("zero_result", res, 32'hDEAD_BEEF);

    run_op(2'b10, 5'd4, 32'h4000_0000, 1'b1);
    check("sra_pos", res, 32'h0400_0000);
    run_op(2'b00, 5'd31, 32'hFFFF_FFFF, 1'b1);
    check("sll31", res, 32'h8000_0000);

    // Second Start two cycles into an SRL by 8 must be dropped.
    @(negedge Clk);
    Start = 1'b1; Op = 2'b01; ShAmt = 5'd8; DataIn = 32'hF000_0000;
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    Start = 1'b1; Op = 2'b00; ShAmt = 5'd1; DataIn = 32'h0000_0003;
    @(negedge Clk);
    Start = 1'b0;
    cyc_cnt = 2;
    while (!Done && cyc_cnt < 100) begin
      @(negedge Clk);
      cyc_cnt++;
    end
    check("ignore_cycles", cyc_cnt, 32'd8);
    check("ignore_result", DataOut, 32'h00F0_0000);

    run_op(2'b11, 5'd1, 32'h0000_0001, 1'b1);
    check("op11_by1", res, exp_ror1);
    run_op(2'b11, 5'd4, 32'h1234_5678, 1'b1);
    check("op11_by4", res, exp_ror4);

    // Asynchronous reset in the middle of a shift.
    @(negedge Clk);
    Start = 1'b1; Op = 2'b00; ShAmt = 5'd10; DataIn = 32'h0000_0001;
    @(negedge Clk);
    Start = 1'b0;
    repeat (2) @(negedge Clk);
    check("mid_busy_before", {31'd0, Busy}, 32'd1);
    #2 Reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check("abort_done", {31'd0, Done}, 32'd0);
    check("abort_dout", DataOut, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    got_done = 1'b0;
    repeat (12) begin
      @(negedge Clk);
      if (Done) got_done = 1'b1;
    end
    check("abort_no_done", {31'd0, got_done}, 32'd0);
    run_op(2'b01, 5'd4, 32'h0000_0100, 1'b1);
    check("post_reset_result", res, 32'h0000_0010);
    check("post_reset_cycles", cyc_cnt, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
